// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, hazard/redirect controls
// from ID, and the IF/ID pipeline register plus fetch statistics.
//   slave  : the fetch stage (drives pc, imem_addr, IF/ID, counters)
//   master : the surrounding pipeline/memory (drives imem_rdata, stall, redirects)
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic [15:0] flush_count;

  modport slave (
    input  imem_rdata, stall, br_taken, br_target, jmp, jmp_target,
    output imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count, flush_count
  );

  modport master (
    output imem_rdata, stall, br_taken, br_target, jmp, jmp_target,
    input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count, flush_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and two
// statistics counters.
// Ports:
//   clk  - system clock, all state changes on posedge
//   rst  - synchronous active-high reset
//   bus  - if_stage_if.slave: imem_addr/imem_rdata, stall, br_taken/br_target,
//          jmp/jmp_target, pc, ifid_instr/ifid_pc4/ifid_valid,
//          fetch_count, flush_count
// Each posedge priority: rst > stall > jmp > br_taken > sequential fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.slave   bus
);

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        redirect;
  logic [31:0] redirect_pc;

  assign pc4      = pc_q + 32'd4;
  assign redirect = bus.jmp | bus.br_taken;

  // Jump outranks branch; low address bits are dropped so fetch stays word-aligned.
  assign redirect_pc = bus.jmp ? {bus.jmp_target[31:2], 2'b00}
                               : {bus.br_target[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_WORD;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else if (!bus.stall) begin
      if (redirect) begin
        // The word fetched this cycle is on the wrong path: replace with a bubble.
        pc_q    <= redirect_pc;
        instr_q <= NOP_WORD;
        pc4_q   <= 32'd0;
        valid_q <= 1'b0;
        if (flush_cnt_q != 16'hFFFF) begin
          flush_cnt_q <= flush_cnt_q + 16'd1;
        end
      end else begin
        pc_q        <= pc4;
        instr_q     <= bus.imem_rdata;
        pc4_q       <= pc4;
        valid_q     <= 1'b1;
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_pc4    = pc4_q;
  assign bus.ifid_valid  = valid_q;
  assign bus.fetch_count = fetch_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule
